// File: rtl/vote_collector_if.sv
// Voting-round bus: round control, per-judge ballots in, round status and result out.
interface vote_collector_if;
  logic       start;
  logic [4:0] vote_en;
  logic [4:0] vote_val;
  logic       busy;
  logic [4:0] voted;
  logic [2:0] yes_cnt;
  logic       y;
  logic       done;
  logic       timed_out;

  // master drives ballots and START, the collector (slave) reports the round
  modport master (
    output start, vote_en, vote_val,
    input  busy, voted, yes_cnt, y, done, timed_out
  );

  modport slave (
    input  start, vote_en, vote_val,
    output busy, voted, yes_cnt, y, done, timed_out
  );
endinterface

// File: rtl/vote_collector.sv
// Five-judge vote collector: accepts one final ballot per judge per round, then
// issues a registered majority decision once all judges voted or the round times out.
module vote_collector #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic              i_clk,
  input  logic              i_rst,
  vote_collector_if.slave   io_vote
);

  typedef enum logic [1:0] {StIdle, StCollect, StHold} state_e;

  localparam logic [7:0] TimerLast = 8'(TIMEOUT_CYC - 1);

  state_e     r_state;
  logic [7:0] r_timer;
  logic [4:0] r_voted;
  logic [2:0] r_yes_cnt;
  logic       r_busy;
  logic       r_y;
  logic       r_done;
  logic       r_timed_out;

  logic [4:0] w_accept;
  logic [2:0] w_yes_add;
  logic       w_all_voted;
  logic       w_decide;

  // New ballots are strobes from judges that have not voted yet; count their yes votes
  always_comb begin
    w_accept  = io_vote.vote_en & ~r_voted;
    w_yes_add = 3'd0;
    for (int i = 0; i < 5; i++) begin
      w_yes_add = w_yes_add + {2'b00, w_accept[i] & io_vote.vote_val[i]};
    end
  end

  // Decision uses the registered ballot set, so all-voted wins over a coincident timeout
  assign w_all_voted = (r_voted == 5'b11111);
  assign w_decide    = w_all_voted || (r_timer == TimerLast);

  // Round FSM with all outputs held in registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= StIdle;
      r_timer     <= 8'd0;
      r_voted     <= 5'd0;
      r_yes_cnt   <= 3'd0;
      r_busy      <= 1'b0;
      r_y         <= 1'b0;
      r_done      <= 1'b0;
      r_timed_out <= 1'b0;
    end else begin
      case (r_state)
        StIdle, StHold: begin
          // DONE is a single-cycle pulse; a START here also clears it
          r_done <= 1'b0;
          if (io_vote.start) begin
            r_state     <= StCollect;
            r_busy      <= 1'b1;
            r_voted     <= 5'd0;
            r_yes_cnt   <= 3'd0;
            r_y         <= 1'b0;
            r_timed_out <= 1'b0;
            r_timer     <= 8'd0;
          end
        end
        StCollect: begin
          if (w_decide) begin
            // ballots presented on the decision edge are dropped
            r_state     <= StHold;
            r_busy      <= 1'b0;
            r_y         <= (r_yes_cnt >= 3'd3);
            r_done      <= 1'b1;
            r_timed_out <= ~w_all_voted;
          end else begin
            r_voted   <= r_voted | w_accept;
            r_yes_cnt <= r_yes_cnt + w_yes_add;
            r_timer   <= r_timer + 8'd1;
          end
        end
        default: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign io_vote.busy      = r_busy;
  assign io_vote.voted     = r_voted;
  assign io_vote.yes_cnt   = r_yes_cnt;
  assign io_vote.y         = r_y;
  assign io_vote.done      = r_done;
  assign io_vote.timed_out = r_timed_out;

endmodule

// File: tb/tb_vote_collector.sv
// Bench for vote_collector: three instances (timeouts 255, 4, 3) share stimulus and are
// compared every cycle against a round-level model, plus a vector table and directed rounds.
module tb_vote_collector;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [4:0] vote_en;
  logic [4:0] vote_val;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  vote_collector_if u_if0 ();
  vote_collector_if u_if1 ();
  vote_collector_if u_if2 ();

  assign u_if0.start = start;
  assign u_if0.vote_en = vote_en;
  assign u_if0.vote_val = vote_val;
  assign u_if1.start = start;
  assign u_if1.vote_en = vote_en;
  assign u_if1.vote_val = vote_val;
  assign u_if2.start = start;
  assign u_if2.vote_en = vote_en;
  assign u_if2.vote_val = vote_val;

  vote_collector #(.TIMEOUT_CYC(255)) u_dut0 (.i_clk(clk), .i_rst(rst), .io_vote(u_if0));
  vote_collector #(.TIMEOUT_CYC(4))   u_dut1 (.i_clk(clk), .i_rst(rst), .io_vote(u_if1));
  vote_collector #(.TIMEOUT_CYC(3))   u_dut2 (.i_clk(clk), .i_rst(rst), .io_vote(u_if2));

  // Round-level model: which judges have a final ballot, how many said yes,
  // how many collecting cycles have elapsed, and the published result.
  int unsigned tmo[3] = '{255, 4, 3};
  bit          m_coll[3];
  bit [4:0]    m_voted[3];
  int          m_yes[3];
  int          m_elapsed[3];
  bit          m_y[3];
  bit          m_done[3];
  bit          m_to[3];

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_coll[k] = 0; m_voted[k] = '0; m_yes[k] = 0; m_elapsed[k] = 0;
      m_y[k] = 0; m_done[k] = 0; m_to[k] = 0;
    end
  endtask

  task automatic model_edge();
    bit all_in;
    if (rst) begin
      model_reset();
      return;
    end
    for (int k = 0; k < 3; k++) begin
      if (m_coll[k]) begin
        all_in = ($countones(m_voted[k]) == 5);
        if (all_in || m_elapsed[k] == int'(tmo[k]) - 1) begin
          m_coll[k] = 0;
          m_y[k]    = (m_yes[k] >= 3);
          m_done[k] = 1;
          m_to[k]   = !all_in;
        end else begin
          for (int i = 0; i < 5; i++) begin
            if (vote_en[i] && !m_voted[k][i]) begin
              m_voted[k][i] = 1;
              if (vote_val[i]) m_yes[k]++;
            end
          end
          m_elapsed[k]++;
        end
      end else if (start) begin
        m_coll[k] = 1; m_voted[k] = '0; m_yes[k] = 0; m_elapsed[k] = 0;
        m_y[k] = 0; m_done[k] = 0; m_to[k] = 0;
      end else begin
        m_done[k] = 0;
      end
    end
  endtask

  function automatic logic [11:0] exp_vec(input int k);
    return {m_coll[k], m_voted[k], 3'(m_yes[k]), m_y[k], m_done[k], m_to[k]};
  endfunction

  function automatic logic [11:0] dut_vec(input int k);
    case (k)
      0: return {u_if0.busy, u_if0.voted, u_if0.yes_cnt, u_if0.y, u_if0.done, u_if0.timed_out};
      1: return {u_if1.busy, u_if1.voted, u_if1.yes_cnt, u_if1.y, u_if1.done, u_if1.timed_out};
      default:
        return {u_if2.busy, u_if2.voted, u_if2.yes_cnt, u_if2.y, u_if2.done, u_if2.timed_out};
    endcase
  endfunction

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string name);
    for (int k = 0; k < 3; k++) check($sformatf("%s dut%0d", name, k), dut_vec(k), exp_vec(k));
  endtask

  // One clock: model consumes the pre-edge inputs, outputs are sampled 1 ns after the edge
  task automatic cycle(input string name);
    model_edge();
    @(posedge clk);
    #1;
    check_all(name);
  endtask

  task automatic drive(input logic s, input logic [4:0] en, input logic [4:0] val);
    start = s; vote_en = en; vote_val = val;
  endtask

  task automatic sync_reset();
    drive(1'b0, 5'd0, 5'd0);
    rst = 1'b1;
    cycle("sync_rst");
    rst = 1'b0;
  endtask

  // Reset asserted between edges must clear outputs without waiting for a clock
  task automatic async_reset(input string name);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_all(name);
    #1;
    rst = 1'b0;
  endtask

  typedef struct packed {
    logic       start;
    logic [4:0] en;
    logic [4:0] val;
    logic       busy;
    logic [4:0] voted;
    logic [2:0] yes;
    logic       y;
    logic       done;
    logic       to;
  } vec_t;

  vec_t tbl[9];

  initial begin
    // judges vote one per cycle 1,0,0,1,0 with judge 0 re-strobing yes in between
    tbl[0] = '{1'b1, 5'b00000, 5'b00000, 1'b1, 5'b00000, 3'd0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 5'b00001, 5'b00001, 1'b1, 5'b00001, 3'd1, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 5'b00010, 5'b00000, 1'b1, 5'b00011, 3'd1, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 5'b00100, 5'b00000, 1'b1, 5'b00111, 3'd1, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 5'b01000, 5'b01000, 1'b1, 5'b01111, 3'd2, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 5'b00001, 5'b00001, 1'b1, 5'b01111, 3'd2, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 5'b10000, 5'b00000, 1'b1, 5'b11111, 3'd2, 1'b0, 1'b0, 1'b0};
    tbl[7] = '{1'b0, 5'b00000, 5'b00000, 1'b0, 5'b11111, 3'd2, 1'b0, 1'b1, 1'b0};
    tbl[8] = '{1'b0, 5'b11111, 5'b11111, 1'b0, 5'b11111, 3'd2, 1'b0, 1'b0, 1'b0};

    rst = 1'b1;
    drive(1'b0, 5'd0, 5'd0);
    model_reset();
    #1;
    check_all("reset");
    check("reset_busy0", dut_vec(0), 12'h000);
    cycle("reset_hold");
    rst = 1'b0;

    // all five on one edge, 3 yes
    drive(1'b1, 5'd0, 5'd0);
    cycle("r28_start");
    drive(1'b0, 5'b11111, 5'b10110);
    cycle("r28_vote");
    check("r28_yes", 12'(u_if0.yes_cnt), 12'd3);
    check("r28_nodone", 12'(u_if0.done), 12'd0);
    drive(1'b0, 5'd0, 5'd0);
    cycle("r28_dec");
    check("r28_result", {9'd0, u_if0.y, u_if0.done, u_if0.timed_out}, 12'b110);
    cycle("r28_hold");
    check("r28_done_drop", {9'd0, u_if0.y, u_if0.done, u_if0.timed_out}, 12'b100);

    for (int r = 0; r < 9; r++) begin
      drive(tbl[r].start, tbl[r].en, tbl[r].val);
      cycle($sformatf("tbl%0d_model", r));
      check($sformatf("tbl%0d", r), dut_vec(0),
            {tbl[r].busy, tbl[r].voted, tbl[r].yes, tbl[r].y, tbl[r].done, tbl[r].to});
    end

    // timeout 4: judges 0..2 yes, 3 and 4 silent
    sync_reset();
    drive(1'b1, 5'd0, 5'd0);
    cycle("r30_start");
    drive(1'b0, 5'b00001, 5'b00001);
    cycle("r30_j0");
    drive(1'b0, 5'b00010, 5'b00010);
    cycle("r30_j1");
    drive(1'b0, 5'b00100, 5'b00100);
    cycle("r30_j2");
    check("r30_still_busy", {10'd0, u_if1.busy, u_if1.done}, 12'b10);
    drive(1'b0, 5'b11000, 5'b11000);
    cycle("r30_dec");
    check("r30_result", dut_vec(1), {1'b0, 5'b00111, 3'd3, 1'b1, 1'b1, 1'b1});
    // START on the DONE edge is taken and DONE drops
    drive(1'b1, 5'd0, 5'd0);
    cycle("r30_restart");
    check("r30_restart", dut_vec(1), {1'b1, 5'b00000, 3'd0, 1'b0, 1'b0, 1'b0});

    // timeout 3: fifth ballot at timer 1, all-voted wins at timer 2
    sync_reset();
    drive(1'b1, 5'd0, 5'd0);
    cycle("r31_start");
    drive(1'b0, 5'b01111, 5'b00011);
    cycle("r31_four");
    drive(1'b0, 5'b10000, 5'b10000);
    cycle("r31_fifth");
    drive(1'b0, 5'd0, 5'd0);
    cycle("r31_dec");
    check("r31_result", dut_vec(2), {1'b0, 5'b11111, 3'd3, 1'b1, 1'b1, 1'b0});

    // async reset after two ballots, then a clean round
    sync_reset();
    drive(1'b1, 5'd0, 5'd0);
    cycle("r32_start");
    drive(1'b0, 5'b00011, 5'b00001);
    cycle("r32_two");
    check("r32_two", 12'(u_if0.voted), 12'b00011);
    drive(1'b0, 5'd0, 5'd0);
    async_reset("r32_async");
    check("r32_clear", dut_vec(0), 12'h000);
    cycle("r32_idle");
    check("r32_idle", dut_vec(0), 12'h000);
    drive(1'b1, 5'd0, 5'd0);
    cycle("r32_restart");
    drive(1'b0, 5'b11111, 5'b11100);
    cycle("r32_vote");
    drive(1'b0, 5'd0, 5'd0);
    cycle("r32_dec");
    check("r32_result", dut_vec(0), {1'b0, 5'b11111, 3'd3, 1'b1, 1'b1, 1'b0});

    // randomized rounds against the model
    for (int n = 0; n < 3000; n++) begin
      start    = ($urandom_range(0, 7) == 0);
      vote_en  = 5'($urandom_range(0, 31) & $urandom_range(0, 31));
      vote_val = 5'($urandom);
      if ($urandom_range(0, 199) == 0) async_reset("rnd_async");
      cycle("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
